dmem_arbiter: RTL

- Shares the single data memory (64 x 32-bit words, combinational read, write on posedge clk) between two requesters.
- Port 0 is the CPU MEM stage; port 1 is the loader/debug master.
- Provides round-robin arbitration and a request/ready handshake.
- Models a programmable access latency and drives the pipeline freeze while the CPU access is outstanding.

---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU = port 0, loader/debug = port 1) in front of a single data memory.
// Access latency is MEM_LATENCY busy cycles plus one done cycle. Define DMEM_ARB_CPU_PRIORITY_EN for fixed CPU priority.
module dmem_arbiter #(
  parameter int DEPTH       = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      state;
  logic        last_grant;
  logic        grant;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [3:0]  cnt;

  logic        pick;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;

  // pick = 1 selects the debug port
  always_comb begin
`ifdef DMEM_ARB_CPU_PRIORITY_EN
    pick = ~cpu_req;
`else
    if (cpu_req && dbg_req) pick = ~last_grant;
    else                    pick = ~cpu_req;
`endif
    sel_we    = pick ? dbg_we    : cpu_we;
    sel_addr  = pick ? dbg_addr  : cpu_addr;
    sel_wdata = pick ? dbg_wdata : cpu_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dbg_req) begin
            grant      <= pick;
            last_grant <= pick;
            we_q       <= sel_we;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            err_q      <= sel_err;
            cnt        <= CNT_INIT;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            data_q <= (we_q || err_q) ? 32'd0 : mem_rdata;
            state  <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic busy;
  logic done;

  always_comb begin
    busy      = (state == BUSY);
    done      = (state == DONE) && !rst;
    mem_addr  = busy ? {2'b00, addr_q[31:2]} : 32'd0;
    mem_wdata = busy ? wdata_q : 32'd0;
    mem_r_en  = busy && !we_q && !err_q && !rst;
    // the write fires only on the final busy cycle, once per access
    mem_w_en  = busy && we_q && !err_q && (cnt == 4'd0) && !rst;
    cpu_ready = done && !grant;
    dbg_ready = done && grant;
    cpu_rdata = cpu_ready ? data_q : 32'd0;
    dbg_rdata = dbg_ready ? data_q : 32'd0;
    cpu_err   = cpu_ready && err_q;
    dbg_err   = dbg_ready && err_q;
    cpu_stall = cpu_req && !cpu_ready;
  end

endmodule
